// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: shares the register file write port between requester A
// (ALU/execute) and requester B (load/multi-cycle) with round-robin arbitration
// on contested cycles. The granted write is registered and drives the register
// file one cycle later.
// Optional feature macro: REGARB_CLEAR_EN -- after reset, walk registers
// 1..NUM_REGS-1 writing zero before any request is accepted.
module regfile_wr_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_reg,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_reg,
  input  logic [DATA_W-1:0] b_data,
  output logic              reg_write,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              conflict,
  output logic              busy
);

  // Output stage and round-robin pointer (0 = A wins the next contest).
  logic              reg_write_q,  reg_write_d;
  logic [ADDR_W-1:0] write_reg_q,  write_reg_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic              conflict_q,   conflict_d;
  logic              rr_ptr_q,     rr_ptr_d;
  logic              in_arb;
  logic              grant_a, grant_b;

`ifdef REGARB_CLEAR_EN
  localparam logic [0:0] ST_ARB   = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(NUM_REGS - 1);

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;

  assign in_arb = (state_q == ST_ARB);
  assign busy   = (state_q == ST_CLEAR);
`else
  assign in_arb = 1'b1;
  assign busy   = 1'b0;
`endif

  // Grants are combinational; readies are held low while reset is asserted.
  assign grant_a = rst_n && in_arb && a_valid && (!b_valid || !rr_ptr_q);
  assign grant_b = rst_n && in_arb && b_valid && (!a_valid ||  rr_ptr_q);
  assign a_ready = grant_a;
  assign b_ready = grant_b;

  // Next-state: clear walk, or load the winning request into the output stage.
  always_comb begin
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    conflict_d   = 1'b0;
    rr_ptr_d     = rr_ptr_q;
`ifdef REGARB_CLEAR_EN
    state_d      = state_q;
    clr_idx_d    = clr_idx_q;
    if (state_q == ST_CLEAR) begin
      reg_write_d  = 1'b1;
      write_reg_d  = clr_idx_q;
      write_data_d = '0;
      clr_idx_d    = clr_idx_q + 1'b1;
      if (clr_idx_q == CLR_LAST) state_d = ST_ARB;
    end else
`endif
    begin
      // Register 0 is hardwired: the write is accepted but never enabled.
      if (grant_a) begin
        reg_write_d  = (a_reg != '0);
        write_reg_d  = a_reg;
        write_data_d = a_data;
      end else if (grant_b) begin
        reg_write_d  = (b_reg != '0);
        write_reg_d  = b_reg;
        write_data_d = b_data;
      end
      conflict_d = a_valid && b_valid;
      // Contested cycle: pointer moves to the loser.
      if (a_valid && b_valid) rr_ptr_d = ~rr_ptr_q;
    end
  end

  // State update with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      conflict_q   <= 1'b0;
      rr_ptr_q     <= 1'b0;
`ifdef REGARB_CLEAR_EN
      state_q      <= ST_CLEAR;
      clr_idx_q    <= ADDR_W'(1);
`endif
    end else begin
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      conflict_q   <= conflict_d;
      rr_ptr_q     <= rr_ptr_d;
`ifdef REGARB_CLEAR_EN
      state_q      <= state_d;
      clr_idx_q    <= clr_idx_d;
`endif
    end
  end

  assign reg_write  = reg_write_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;
  assign conflict   = conflict_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed self-checking bench for regfile_wr_arbiter. Inputs change 1ns after
// posedge; readies are checked 2ns after posedge, registered outputs 1ns after.
module tb_regfile_wr_arbiter;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              a_valid, b_valid;
  logic              a_ready, b_ready;
  logic [ADDR_W-1:0] a_reg, b_reg;
  logic [DATA_W-1:0] a_data, b_data;
  logic              reg_write;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic              conflict;
  logic              busy;

  int vecs = 0;
  int errs = 0;

  regfile_wr_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .conflict(conflict), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    a_valid = 0; b_valid = 0; a_reg = '0; b_reg = '0; a_data = '0; b_data = '0;
  endtask

  // Release reset; with the clear walk built in, sit out the 31 clear cycles.
  task automatic release_reset();
    rst_n = 1;
`ifdef REGARB_CLEAR_EN
    repeat (31) tick();
`endif
  endtask

  task automatic do_reset();
    idle(); rst_n = 0; tick(); release_reset();
  endtask

  task automatic test_reset();
    idle(); rst_n = 0; a_valid = 1; b_valid = 1; a_reg = 5'd3; b_reg = 5'd4;
    tick(); tick(); #1;
    vecs++; if (a_ready !== 1'b0) begin errs++; $display("FAIL reset_a_ready got %b exp 0", a_ready); end
    vecs++; if (b_ready !== 1'b0) begin errs++; $display("FAIL reset_b_ready got %b exp 0", b_ready); end
    vecs++; if (reg_write !== 1'b0) begin errs++; $display("FAIL reset_reg_write got %b exp 0", reg_write); end
    vecs++; if (write_reg !== 5'd0) begin errs++; $display("FAIL reset_write_reg got %0d exp 0", write_reg); end
    vecs++; if (write_data !== 32'd0) begin errs++; $display("FAIL reset_write_data got %h exp 0", write_data); end
    vecs++; if (conflict !== 1'b0) begin errs++; $display("FAIL reset_conflict got %b exp 0", conflict); end
`ifdef REGARB_CLEAR_EN
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL reset_busy got %b exp 1", busy); end
`else
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b exp 0", busy); end
`endif
    idle(); release_reset();
  endtask

  task automatic test_single();
    do_reset();
    a_valid = 1; a_reg = 5'd5; a_data = 32'hDEADBEEF; #1;
    vecs++; if (a_ready !== 1'b1) begin errs++; $display("FAIL single_a_ready got %b exp 1", a_ready); end
    vecs++; if (b_ready !== 1'b0) begin errs++; $display("FAIL single_b_ready got %b exp 0", b_ready); end
    tick(); idle();
    vecs++; if (reg_write !== 1'b1) begin errs++; $display("FAIL single_reg_write got %b exp 1", reg_write); end
    vecs++; if (write_reg !== 5'd5) begin errs++; $display("FAIL single_write_reg got %0d exp 5", write_reg); end
    vecs++; if (write_data !== 32'hDEADBEEF) begin errs++; $display("FAIL single_write_data got %h exp deadbeef", write_data); end
    vecs++; if (conflict !== 1'b0) begin errs++; $display("FAIL single_conflict got %b exp 0", conflict); end
    tick();
    vecs++; if (reg_write !== 1'b0) begin errs++; $display("FAIL single_idle_reg_write got %b exp 0", reg_write); end
    vecs++; if (write_reg !== 5'd5) begin errs++; $display("FAIL single_hold_write_reg got %0d exp 5", write_reg); end
  endtask

  // Held contest alternates A,B,A,B; conflict follows one cycle behind.
  task automatic test_back_to_back();
    logic [ADDR_W-1:0] exp_reg;
    do_reset();
    a_valid = 1; b_valid = 1; a_reg = 5'd1; b_reg = 5'd2; a_data = 32'h11; b_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      vecs++; if (a_ready !== (i % 2 == 0)) begin errs++; $display("FAIL b2b_a_ready[%0d] got %b exp %b", i, a_ready, (i % 2 == 0)); end
      vecs++; if (b_ready !== (i % 2 == 1)) begin errs++; $display("FAIL b2b_b_ready[%0d] got %b exp %b", i, b_ready, (i % 2 == 1)); end
      tick();
      exp_reg = (i % 2 == 0) ? 5'd1 : 5'd2;
      vecs++; if (reg_write !== 1'b1) begin errs++; $display("FAIL b2b_reg_write[%0d] got %b exp 1", i, reg_write); end
      vecs++; if (write_reg !== exp_reg) begin errs++; $display("FAIL b2b_write_reg[%0d] got %0d exp %0d", i, write_reg, exp_reg); end
      vecs++; if (conflict !== 1'b1) begin errs++; $display("FAIL b2b_conflict[%0d] got %b exp 1", i, conflict); end
    end
    idle(); tick();
    vecs++; if (conflict !== 1'b0) begin errs++; $display("FAIL b2b_conflict_end got %b exp 0", conflict); end
    vecs++; if (reg_write !== 1'b0) begin errs++; $display("FAIL b2b_reg_write_end got %b exp 0", reg_write); end
  endtask

  // Uncontested B grants must not move the pointer.
  task automatic test_b_only();
    do_reset();
    b_valid = 1; b_reg = 5'd3; b_data = 32'h3333;
    for (int i = 0; i < 3; i++) begin
      #1;
      vecs++; if (b_ready !== 1'b1 || a_ready !== 1'b0) begin errs++; $display("FAIL bonly_ready[%0d] got a=%b b=%b exp a=0 b=1", i, a_ready, b_ready); end
      tick();
      vecs++; if (write_reg !== 5'd3 || reg_write !== 1'b1 || conflict !== 1'b0) begin errs++; $display("FAIL bonly_out[%0d] got we=%b reg=%0d cf=%b exp we=1 reg=3 cf=0", i, reg_write, write_reg, conflict); end
    end
    a_valid = 1; a_reg = 5'd4; a_data = 32'h4444; #1;
    vecs++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin errs++; $display("FAIL bonly_contest1 got a=%b b=%b exp a=1 b=0", a_ready, b_ready); end
    tick(); #1;
    vecs++; if (a_ready !== 1'b0 || b_ready !== 1'b1) begin errs++; $display("FAIL bonly_contest2 got a=%b b=%b exp a=0 b=1", a_ready, b_ready); end
    vecs++; if (write_reg !== 5'd4 || write_data !== 32'h4444) begin errs++; $display("FAIL bonly_contest_out got reg=%0d data=%h exp reg=4 data=4444", write_reg, write_data); end
    idle(); tick();
  endtask

  task automatic test_reg0();
    do_reset();
    a_valid = 1; a_reg = 5'd0; a_data = 32'h1234; #1;
    vecs++; if (a_ready !== 1'b1) begin errs++; $display("FAIL reg0_a_ready got %b exp 1", a_ready); end
    tick();
    a_reg = 5'd7; a_data = 32'h77;
    vecs++; if (reg_write !== 1'b0) begin errs++; $display("FAIL reg0_reg_write got %b exp 0", reg_write); end
    vecs++; if (write_reg !== 5'd0 || write_data !== 32'h1234) begin errs++; $display("FAIL reg0_load got reg=%0d data=%h exp reg=0 data=1234", write_reg, write_data); end
    #1;
    vecs++; if (a_ready !== 1'b1) begin errs++; $display("FAIL reg0_next_a_ready got %b exp 1", a_ready); end
    tick();
    a_valid = 0; b_valid = 1; b_reg = 5'd0; b_data = 32'h55;
    vecs++; if (reg_write !== 1'b1 || write_reg !== 5'd7 || write_data !== 32'h77) begin errs++; $display("FAIL reg0_next_out got we=%b reg=%0d data=%h exp we=1 reg=7 data=77", reg_write, write_reg, write_data); end
    tick(); idle();
    vecs++; if (reg_write !== 1'b0 || write_data !== 32'h55) begin errs++; $display("FAIL reg0_b got we=%b data=%h exp we=0 data=55", reg_write, write_data); end
  endtask

  // Reset while the output stage is about to write; pointer returns to A.
  task automatic test_reset_mid();
    do_reset();
    a_valid = 1; b_valid = 1; a_reg = 5'd9; b_reg = 5'd10; a_data = 32'h99; b_data = 32'hAA;
    tick();
    rst_n = 0; #1;
    vecs++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin errs++; $display("FAIL mid_ready_forced got a=%b b=%b exp 0 0", a_ready, b_ready); end
    tick();
    vecs++; if (reg_write !== 1'b0 || conflict !== 1'b0) begin errs++; $display("FAIL mid_outputs got we=%b cf=%b exp 0 0", reg_write, conflict); end
    release_reset(); #1;
    vecs++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin errs++; $display("FAIL mid_rr_ptr got a=%b b=%b exp a=1 b=0", a_ready, b_ready); end
    idle(); tick(); tick();
  endtask

`ifdef REGARB_CLEAR_EN
  task automatic test_clear();
    idle(); rst_n = 0; a_valid = 1; a_reg = 5'd4; a_data = 32'h44;
    tick();
    rst_n = 1;
    for (int k = 1; k <= 31; k++) begin
      #1;
      vecs++; if (busy !== 1'b1 || a_ready !== 1'b0) begin errs++; $display("FAIL clear_busy[%0d] got busy=%b a_ready=%b exp 1 0", k, busy, a_ready); end
      tick();
      vecs++; if (reg_write !== 1'b1 || write_reg !== ADDR_W'(k) || write_data !== 32'd0) begin errs++; $display("FAIL clear_write[%0d] got we=%b reg=%0d data=%h exp we=1 reg=%0d data=0", k, reg_write, write_reg, write_data, k); end
    end
    #1;
    vecs++; if (busy !== 1'b0 || a_ready !== 1'b1) begin errs++; $display("FAIL clear_done got busy=%b a_ready=%b exp 0 1", busy, a_ready); end
    idle(); tick();
  endtask
`endif

  initial begin
    idle(); rst_n = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_b_only();
    test_reg0();
    test_reset_mid();
`ifdef REGARB_CLEAR_EN
    test_clear();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
